camera_power_seq: RTL and testbench
===================================

# camera_power_seq

Power-up and bring-up sequencer placed directly upstream of the camera I2C configuration block. It holds the sensor in shutdown and then releases it after programmed delays. It then releases the configuration block from reset and waits for its done flag with a timeout. Finally it checks the chip ID the configuration block read back and retries the whole sequence a bounded number of times before declaring success or failure to the MIPI receive path.

## Interface
Parameters:
- T_PWR_CYC, default 100000: cycles the sensor is held in shutdown (cam_xclr low) before release; minimum 2.
- T_RST_CYC, default 50000: cycles from cam_xclr rise to cfg_rstn rise; minimum 2.
- T_CFG_TIMEOUT_CYC, default 50000000: maximum cycles in CFG_RUN waiting for cfg_done.
- MAX_RETRY, default 3: retries after the first attempt; range 0..15.
- EXP_CHIP_ID, default 16'h0219: expected {chip_version_h, chip_version_l}.

Ports:
- clk  in  1  system clock, same domain as the configuration block.
- rstn  in  1  asynchronous, active-low reset.
- restart  in  1  single-cycle pulse; honoured only in READY or FAIL.
- cfg_done  in  1  config-complete flag from the configuration block; level.
- chip_version_h  in  8  chip ID high byte read back by the configuration block.
- chip_version_l  in  8  chip ID low byte read back by the configuration block.
- cam_xclr  out  1  sensor shutdown release to the pin; 0 = shutdown.
- cfg_rstn  out  1  active-low reset driven to the configuration block.
- cam_ready  out  1  high while in READY.
- cam_fail  out  1  high while in FAIL.
- retry_cnt  out  4  number of retries consumed in the current run.
- id_mismatch  out  1  sticky flag: at least one CHECK failed in the current run.

## Operation
- States: PWR_WAIT, RST_WAIT, CFG_RUN, CHECK, READY, FAIL. There is a single dwell counter `cnt`, cleared on every state entry.
- Reset value of every output is 0 (cam_xclr=0, cfg_rstn=0, cam_ready=0, cam_fail=0, retry_cnt=0, id_mismatch=0). Reset state is PWR_WAIT with cnt=0.
- PWR_WAIT: cam_xclr=0, cfg_rstn=0. When cnt==T_PWR_CYC-1, go to RST_WAIT.
- RST_WAIT: cam_xclr=1, cfg_rstn=0. When cnt==T_RST_CYC-1, go to CFG_RUN.
- CFG_RUN: cam_xclr=1, cfg_rstn=1.
  - If cfg_done=1, go to CHECK.
  - Otherwise, if cnt==T_CFG_TIMEOUT_CYC-1, the attempt fails (timeout).
  - If cfg_done and the timeout coincide, cfg_done wins.
- CHECK (exactly 1 cycle): compare {chip_version_h, chip_version_l} with EXP_CHIP_ID.
  - Equal: go to READY.
  - Not equal: set id_mismatch; the attempt fails.
- Failed attempt:
  - If retry_cnt==MAX_RETRY, go to FAIL.
  - Otherwise increment retry_cnt and go to PWR_WAIT. This drops cam_xclr and cfg_rstn on the same edge, giving a full power cycle.
- READY: cam_ready=1, other outputs hold.
- FAIL: cam_fail=1, cam_xclr=0, cfg_rstn=0.
- restart in READY or FAIL: go to PWR_WAIT and clear retry_cnt and id_mismatch. restart is ignored in all other states.
- cnt width = clog2 of the largest of the three T_* parameters. cnt never wraps, because every state that uses it exits at its terminal count.
- Asserting rstn at any point, mid-sequence included, returns the block to reset values immediately. The sensor and configuration block are therefore re-held.

## Timing
- All outputs are registered and decoded from the state register; no combinational path from inputs to outputs.
- cam_xclr rises T_PWR_CYC edges after the first edge following rstn release.
- cfg_rstn rises T_RST_CYC edges after cam_xclr rises.
- cfg_done sampled high at edge N: CHECK occupies cycle N+1, and cam_ready is high from edge N+2.
- Timeout: with cfg_done stuck low, the retry (cam_xclr falling) occurs T_CFG_TIMEOUT_CYC edges after cfg_rstn rises.
- cfg_done is ignored outside CFG_RUN. A stale high value cannot occur there, because cfg_rstn low resets the configuration block.

## Structure
- Shared package cam_ctrl_pkg holds the state encoding localparams and the default EXP_CHIP_ID constant.
- Sub-module dwell_timer: a generic up-counter with clear and terminal-compare, parameterised by width. It is instantiated once, and each state's compare value is muxed in.

## Test plan
Run with T_PWR_CYC=16, T_RST_CYC=8, T_CFG_TIMEOUT_CYC=100, MAX_RETRY=2, EXP_CHIP_ID=16'h0219.
1. Nominal bring-up: model raises cfg_done 40 cycles after cfg_rstn rises with ID 0x0219 -> cam_xclr rises at edge 16, cfg_rstn at edge 24, cam_ready at edge 24+40+2, retry_cnt=0.
2. Timeout: cfg_done held low -> three attempts, each 16+8+100 edges. retry_cnt ends at 2, then cam_fail=1 with cam_xclr=0 and cfg_rstn=0.
3. ID mismatch then match: first attempt returns 0x0000, second returns 0x0219 -> id_mismatch=1, retry_cnt=1, cam_ready=1.
4. Simultaneous cfg_done and timeout on cycle 99 of CFG_RUN with ID 0x0219 -> CHECK passes, cam_ready=1, retry_cnt=0.
5. Restart and ignore: restart pulse in FAIL -> PWR_WAIT with retry_cnt=0 and id_mismatch=0. restart during RST_WAIT -> no effect on timing.
6. rstn asserted mid-CFG_RUN -> all outputs 0 asynchronously. After release, the full sequence repeats from edge 0.

Source files
------------

// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the camera bring-up sequencer: state encoding and
// the default sensor chip ID.
package cam_ctrl_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        RST_WAIT = 3'd1,
        CFG_RUN  = 3'd2,
        CHECK    = 3'd3,
        READY    = 3'd4,
        FAIL     = 3'd5
    } cam_state_t;

    localparam logic [15:0] DEFAULT_EXP_CHIP_ID = 16'h0219;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/camera_power_seq_dwell_timer.sv
// Generic dwell up-counter with synchronous clear, count enable and a
// terminal-count compare against a per-state limit.
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         at_limit
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign at_limit = (count_reg == limit);

endmodule

// File: rtl/camera_power_seq.sv
// Camera power-up / bring-up sequencer: shutdown hold, config-block reset
// release, config-done wait with timeout, chip ID check and bounded retries.
module camera_power_seq
    import cam_ctrl_pkg::*;
#(
    parameter int          T_PWR_CYC         = 100000,
    parameter int          T_RST_CYC         = 50000,
    parameter int          T_CFG_TIMEOUT_CYC = 50000000,
    parameter int          MAX_RETRY         = 3,
    parameter logic [15:0] EXP_CHIP_ID       = DEFAULT_EXP_CHIP_ID
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       restart,
    input  logic       cfg_done,
    input  logic [7:0] chip_version_h,
    input  logic [7:0] chip_version_l,
    output logic       cam_xclr,
    output logic       cfg_rstn,
    output logic       cam_ready,
    output logic       cam_fail,
    output logic [3:0] retry_cnt,
    output logic       id_mismatch
);

    localparam int T_MAX = max3(T_PWR_CYC, T_RST_CYC, T_CFG_TIMEOUT_CYC);
    localparam int CNT_W = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;

    cam_state_t   state_reg, state_next;
    logic [3:0]   retry_reg, retry_next;
    logic         mismatch_reg, mismatch_next;
    logic         xclr_reg, cfg_rstn_reg, ready_reg, fail_reg;
    logic         attempt_fail;
    logic [CNT_W-1:0] cnt_limit;
    logic         cnt_done;
    logic         cnt_clear;
    logic         cnt_enable;

    // One dwell counter shared by all timed states; restarted on every state entry.
    assign cnt_clear  = (state_next != state_reg);
    assign cnt_enable = (state_reg == PWR_WAIT) || (state_reg == RST_WAIT) ||
                        (state_reg == CFG_RUN);

    always_comb begin
        cnt_limit = '0;
        case (state_reg)
            PWR_WAIT: cnt_limit = CNT_W'(T_PWR_CYC - 1);
            RST_WAIT: cnt_limit = CNT_W'(T_RST_CYC - 1);
            CFG_RUN:  cnt_limit = CNT_W'(T_CFG_TIMEOUT_CYC - 1);
            default:  cnt_limit = '0;
        endcase
    end

    dwell_timer #(
        .W(CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .limit    (cnt_limit),
        .at_limit (cnt_done)
    );

    always_comb begin
        state_next    = state_reg;
        retry_next    = retry_reg;
        mismatch_next = mismatch_reg;
        attempt_fail  = 1'b0;
        case (state_reg)
            PWR_WAIT: if (cnt_done) state_next = RST_WAIT;
            RST_WAIT: if (cnt_done) state_next = CFG_RUN;
            CFG_RUN: begin
                // A done flag arriving on the timeout cycle still counts.
                if (cfg_done) state_next = CHECK;
                else if (cnt_done) attempt_fail = 1'b1;
            end
            CHECK: begin
                if ({chip_version_h, chip_version_l} == EXP_CHIP_ID) begin
                    state_next = READY;
                end else begin
                    mismatch_next = 1'b1;
                    attempt_fail  = 1'b1;
                end
            end
            READY, FAIL: begin
                if (restart) begin
                    state_next    = PWR_WAIT;
                    retry_next    = '0;
                    mismatch_next = 1'b0;
                end
            end
            default: state_next = PWR_WAIT;
        endcase

        if (attempt_fail) begin
            if (retry_reg == 4'(MAX_RETRY)) begin
                state_next = FAIL;
            end else begin
                retry_next = retry_reg + 4'd1;
                state_next = PWR_WAIT;
            end
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= PWR_WAIT;
            retry_reg    <= '0;
            mismatch_reg <= 1'b0;
            xclr_reg     <= 1'b0;
            cfg_rstn_reg <= 1'b0;
            ready_reg    <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            retry_reg    <= retry_next;
            mismatch_reg <= mismatch_next;
            xclr_reg     <= state_next inside {RST_WAIT, CFG_RUN, CHECK, READY};
            cfg_rstn_reg <= state_next inside {CFG_RUN, CHECK, READY};
            ready_reg    <= (state_next == READY);
            fail_reg     <= (state_next == FAIL);
        end
    end

    assign cam_xclr    = xclr_reg;
    assign cfg_rstn    = cfg_rstn_reg;
    assign cam_ready   = ready_reg;
    assign cam_fail    = fail_reg;
    assign retry_cnt   = retry_reg;
    assign id_mismatch = mismatch_reg;

endmodule

// File: tb/tb_camera_power_seq.sv
// Scoreboard bench for camera_power_seq: an arithmetic timeline model predicts
// every output change; a negedge monitor compares each observed change in order.
module tb_camera_power_seq;

    localparam int          P    = 16;
    localparam int          R    = 8;
    localparam int          TC   = 100;
    localparam int          MAXR = 2;
    localparam logic [15:0] EXP  = 16'h0219;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       restart = 1'b0;
    logic       cfg_done = 1'b0;
    logic [7:0] chip_version_h = 8'h00;
    logic [7:0] chip_version_l = 8'h00;
    logic       cam_xclr, cfg_rstn, cam_ready, cam_fail, id_mismatch;
    logic [3:0] retry_cnt;

    camera_power_seq #(
        .T_PWR_CYC         (P),
        .T_RST_CYC         (R),
        .T_CFG_TIMEOUT_CYC (TC),
        .MAX_RETRY         (MAXR),
        .EXP_CHIP_ID       (EXP)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .restart        (restart),
        .cfg_done       (cfg_done),
        .chip_version_h (chip_version_h),
        .chip_version_l (chip_version_l),
        .cam_xclr       (cam_xclr),
        .cfg_rstn       (cfg_rstn),
        .cam_ready      (cam_ready),
        .cam_fail       (cam_fail),
        .retry_cnt      (retry_cnt),
        .id_mismatch    (id_mismatch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic        xclr;
        logic        rst;
        logic        ready;
        logic        fail;
        logic [3:0]  retry;
        logic        idm;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Edges since the last reset release (edge 1 is the first one).
    int cyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Per-attempt stimulus plan and the timeline the model derives from it.
    int          att_d    [0:15];
    logic [15:0] att_id   [0:15];
    int          att_base [0:15];
    int          att_c    [0:15];
    int          att_end  [0:15];
    int          n_used;
    bit          run_ok;
    int          run_end;
    int          base;

    task automatic push(input int c, input logic x, input logic r, input logic rd,
                        input logic f, input logic [3:0] rt, input logic m);
        ev_t e;
        e.cyc = 32'(c); e.xclr = x; e.rst = r; e.ready = rd;
        e.fail = f; e.retry = rt; e.idm = m;
        exp_q.push_back(e);
    endtask

    // Timeline: xclr at base+P, cfg_rstn at +R, then done/ID or timeout decides.
    task automatic model_run(input int start);
        int b;
        bit m;
        int e;
        b = start;
        m = 1'b0;
        n_used = 0;
        for (int i = 0; i <= MAXR; i++) begin
            n_used = i + 1;
            att_base[i] = b;
            push(b + P, 1, 0, 0, 0, 4'(i), m);
            att_c[i] = b + P + R;
            push(att_c[i], 1, 1, 0, 0, 4'(i), m);
            if (att_d[i] >= 0) begin
                e = att_c[i] + att_d[i] + 2;
                if (att_id[i] == EXP) begin
                    push(e, 1, 1, 1, 0, 4'(i), m);
                    att_end[i] = e;
                    run_end = e;
                    run_ok = 1'b1;
                    return;
                end
                m = 1'b1;
            end else begin
                e = att_c[i] + TC;
            end
            att_end[i] = e;
            if (i == MAXR) begin
                push(e, 0, 0, 0, 1, 4'(i), m);
                run_end = e;
                run_ok = 1'b0;
                return;
            end
            push(e, 0, 0, 0, 0, 4'(i + 1), m);
            b = e;
        end
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_run(input int rs_off);
        for (int i = 0; i < n_used; i++) begin
            wait_until(att_base[i]);
            {chip_version_h, chip_version_l} = att_id[i];
            if (i == 0 && rs_off > 0) begin
                wait_until(att_base[0] + rs_off);
                restart = 1'b1;
                wait_until(att_base[0] + rs_off + 1);
                restart = 1'b0;
            end
            if (att_d[i] >= 0) begin
                wait_until(att_c[i] + att_d[i]);
                cfg_done = 1'b1;
            end
            wait_until(att_end[i]);
            if (!(run_ok && i == n_used - 1)) cfg_done = 1'b0;
        end
    endtask

    task automatic do_restart();
        int k;
        k = run_end + int'($urandom_range(1, 5));
        push(k, 0, 0, 0, 0, 4'd0, 1'b0);
        wait_until(k - 1);
        restart = 1'b1;
        cfg_done = 1'b0;
        wait_until(k);
        restart = 1'b0;
        base = k;
    endtask

    function automatic logic [15:0] bad_id();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == EXP) v = v ^ 16'h0001;
        return v;
    endfunction

    task automatic randomize_plan();
        int kind;
        for (int i = 0; i <= MAXR; i++) begin
            kind = int'($urandom_range(0, 2));
            att_d[i]  = (kind == 0) ? -1 : int'($urandom_range(0, TC - 1));
            att_id[i] = (kind == 2) ? EXP : bad_id();
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) begin
            att_d[i] = -1;
            att_id[i] = 16'h0000;
        end
    endtask

    // Monitor: every change of any output (or a reset assertion) is one transaction.
    initial begin
        ev_t obs, prev, e;
        bit  fire;
        logic rstn_seen;
        prev = '0;
        rstn_seen = 1'b1;
        forever begin
            @(negedge clk);
            obs.cyc = 32'(cyc); obs.xclr = cam_xclr; obs.rst = cfg_rstn;
            obs.ready = cam_ready; obs.fail = cam_fail; obs.retry = retry_cnt;
            obs.idm = id_mismatch;
            if (!rstn) fire = rstn_seen;
            else       fire = (obs[8:0] != prev[8:0]);
            rstn_seen = rstn;
            if (fire) begin
                n_checks++;
                $display("event cyc=%0d xclr=%b cfg_rstn=%b ready=%b fail=%b retry=%0d idm=%b",
                         obs.cyc, obs.xclr, obs.rst, obs.ready, obs.fail, obs.retry, obs.idm);
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got cyc=%0d outs=%b, required no change",
                             obs.cyc, obs[8:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (e != obs) begin
                        n_fail++;
                        $display("FAIL event_match: got cyc=%0d x=%b r=%b rdy=%b f=%b rt=%0d m=%b, required cyc=%0d x=%b r=%b rdy=%b f=%b rt=%0d m=%b",
                                 obs.cyc, obs.xclr, obs.rst, obs.ready, obs.fail, obs.retry, obs.idm,
                                 e.cyc, e.xclr, e.rst, e.ready, e.fail, e.retry, e.idm);
                    end
                end
            end
            prev = obs;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs;
        clear_plan();
        push(0, 0, 0, 0, 0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Nominal bring-up.
        att_d[0] = 40; att_id[0] = EXP;
        model_run(0); drive_run(0); do_restart();

        // All attempts time out.
        clear_plan();
        model_run(base); drive_run(0); do_restart();

        // ID mismatch then match.
        clear_plan();
        att_d[0] = int'($urandom_range(0, TC - 1)); att_id[0] = 16'h0000;
        att_d[1] = int'($urandom_range(0, TC - 1)); att_id[1] = EXP;
        model_run(base); drive_run(0); do_restart();

        // cfg_done on the timeout cycle.
        clear_plan();
        att_d[0] = TC - 1; att_id[0] = EXP;
        model_run(base); drive_run(0); do_restart();

        // Restart during RST_WAIT is ignored.
        clear_plan();
        att_d[0] = int'($urandom_range(0, TC - 1)); att_id[0] = EXP;
        model_run(base); drive_run(P + int'($urandom_range(0, R - 2))); do_restart();

        for (int n = 0; n < 8; n++) begin
            clear_plan();
            randomize_plan();
            rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, P + R - 2)) : 0;
            model_run(base); drive_run(rs); do_restart();
        end

        // Asynchronous reset in the middle of CFG_RUN.
        clear_plan();
        push(base + P, 1, 0, 0, 0, 4'd0, 1'b0);
        push(base + P + R, 1, 1, 0, 0, 4'd0, 1'b0);
        push(0, 0, 0, 0, 0, 4'd0, 1'b0);
        wait_until(base + P + R + 30);
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        att_d[0] = int'($urandom_range(0, TC - 1)); att_id[0] = EXP;
        model_run(0); drive_run(0);

        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: %0d expected events never observed, required 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
